// File: rtl/reg_writeback_queue_pkg.sv
// Shared register file geometry and the write-back queue entry type.
package regfile_pkg;
  localparam int N         = 16;
  localparam int ADDR_SIZE = 3;
  localparam int REG_COUNT = 8;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [N-1:0]         data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_queue_wb_fifo.sv
// In-order FIFO of write-back entries; exposes every slot so the top can forward pending data.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int depth = 2
) (
  input  logic                       Clock,
  input  logic                       nReset,
  input  logic                       push,
  input  logic                       pop,
  input  wb_entry_t                  wentry,
  output logic [$clog2(depth)-1:0]   head,
  output logic [$clog2(depth):0]     count,
  output logic [depth-1:0]           valid,
  output wb_entry_t [depth-1:0]      entries
);
  localparam int PW = $clog2(depth);

  logic [PW-1:0] tail;

  // The top never pushes into a full queue or pops an empty one, so on a
  // simultaneous push/pop the head and tail slots are always distinct.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid   <= '0;
      entries <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push) begin
        entries[tail] <= wentry;
        valid[tail]   <= 1'b1;
        tail          <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// Buffers datapath result writes, drains one per cycle onto the register file
// write port, and forwards queued data to the decode read ports.
module reg_writeback_queue
  import regfile_pkg::*;
#(
  parameter int n         = 16,
  parameter int addr_size = 3,
  parameter int depth     = 2
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [addr_size-1:0] InAddr,
  input  logic [n-1:0]         InData,
  input  logic                 Hold,
  output logic                 We,
  output logic [addr_size-1:0] Rw,
  output logic [n-1:0]         WData,
  input  logic [addr_size-1:0] Rs1,
  input  logic [addr_size-1:0] Rs2,
  input  logic [n-1:0]         RfRd1,
  input  logic [n-1:0]         RfRd2,
  output logic [n-1:0]         Rd1,
  output logic [n-1:0]         Rd2,
  output logic                 Pending
);
  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;

  logic [PW-1:0]         head;
  logic [CW-1:0]         count;
  logic [depth-1:0]      valid;
  wb_entry_t [depth-1:0] entries;
  wb_entry_t             head_e;
  wb_entry_t             in_e;
  logic                  push;
  logic                  pop;
  logic [PW-1:0]         idx;

  assign in_e    = '{addr: InAddr, data: InData};
  assign head_e  = entries[head];
  assign Pending = (count != '0);
  assign InReady = (count != CW'(depth));
  assign push    = InValid && InReady;
  assign pop     = Pending && !Hold;

  assign We    = pop;
  assign Rw    = Pending ? head_e.addr : '0;
  assign WData = Pending ? head_e.data : '0;

  wb_fifo #(.depth(depth)) u_fifo (
    .Clock   (Clock),
    .nReset  (nReset),
    .push    (push),
    .pop     (pop),
    .wentry  (in_e),
    .head    (head),
    .count   (count),
    .valid   (valid),
    .entries (entries)
  );

  // Walk oldest to newest so the last match, i.e. the newest write, wins.
  always_comb begin
    Rd1 = RfRd1;
    Rd2 = RfRd2;
    idx = '0;
    for (int k = 0; k < depth; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && entries[idx].addr == Rs1) Rd1 = entries[idx].data;
      if (valid[idx] && entries[idx].addr == Rs2) Rd2 = entries[idx].data;
    end
  end
endmodule
